// File: rtl/pitch_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : pitch_frame_sequencer
// Brief   : Admits whole FFT frames to the HPS and phase units, gathers the
//           peak bin and tracked-bin phase, and publishes one result per frame.
// Revision: 1.0 - initial release
// ============================================================================
module pitch_frame_sequencer #(
  parameter int FRAME_LEN   = 1024,
  parameter int K_WIDTH     = 16,
  parameter int PHASE_WIDTH = 24,
  parameter int TIMEOUT     = 4095
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [79:0]            fft_data,
  input  logic [15:0]            fft_user,
  input  logic                   fft_valid,
  input  logic                   fft_last,
  output logic [79:0]            fwd_data,
  output logic [15:0]            fwd_user,
  output logic                   fwd_valid,
  output logic                   fwd_last,
  input  logic [K_WIDTH-1:0]     k_max,
  input  logic                   k_max_valid,
  input  logic [PHASE_WIDTH-1:0] phase_in,
  input  logic [K_WIDTH-1:0]     phase_bin,
  input  logic                   phase_in_valid,
  input  logic                   phase_in_last,
  output logic [K_WIDTH-1:0]     res_k_max,
  output logic [PHASE_WIDTH-1:0] res_phase,
  output logic                   res_valid,
  output logic                   busy,
  output logic [7:0]             drop_count,
  output logic                   err_len,
  output logic                   err_timeout
);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_stream = 3'd1;
  localparam logic [2:0] c_st_wait   = 3'd2;
  localparam logic [2:0] c_st_done   = 3'd3;
  localparam logic [2:0] c_st_drop   = 3'd4;

  localparam int c_cnt_w = $clog2(FRAME_LEN + 1);
  localparam int c_tmo_w = $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FRAME_LEN - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_sat  = c_cnt_w'(FRAME_LEN);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);
  localparam bit                 c_single   = (FRAME_LEN == 1);

  logic [2:0]             r_state;
  logic [2:0]             w_state_nxt;
  logic [c_cnt_w-1:0]     r_bin_cnt;
  logic [c_tmo_w-1:0]     r_tmo;
  logic                   r_got_k;
  logic                   r_got_p;
  logic                   r_inflight;
  logic [K_WIDTH-1:0]     r_k_max_hold;
  logic [K_WIDTH-1:0]     r_target_bin;
  logic [PHASE_WIDTH-1:0] r_phase_hold;

  logic                   w_got_k;
  logic                   w_got_p;
  logic                   w_in_gate;
  logic                   w_inflight_nxt;
  logic                   w_start;
  logic                   w_fwd_en;
  logic                   w_len_err;
  logic                   w_drop_inc;
  logic                   w_res_fire;
  logic                   w_timeout;
  logic [c_cnt_w-1:0]     w_beat_idx;
  logic [K_WIDTH-1:0]     w_k_hold_nxt;
  logic [PHASE_WIDTH-1:0] w_phase_hold_nxt;

  assign w_got_k = r_got_k | k_max_valid;
  assign w_got_p = r_got_p | (phase_in_valid & phase_in_last);

  // DONE only accepts a new frame when no dropped frame is still streaming past.
  assign w_in_gate = (r_state == c_st_idle) || ((r_state == c_st_done) && !r_inflight);

  // Tracks a discarded frame that started while waiting for results.
  assign w_inflight_nxt = fft_valid ? !fft_last : r_inflight;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle, c_st_done: begin
        if ((r_state == c_st_done) && r_inflight) begin
          w_state_nxt = (fft_valid && fft_last) ? c_st_idle : c_st_drop;
        end else if (w_start) begin
          w_state_nxt = fft_last ? c_st_wait : c_st_stream;
        end else if (fft_valid && !fft_last) begin
          w_state_nxt = c_st_drop;
        end else begin
          w_state_nxt = c_st_idle;
        end
      end
      c_st_stream: begin
        if (fft_valid && fft_last) begin
          w_state_nxt = c_st_wait;
        end
      end
      c_st_wait: begin
        if (w_got_k && w_got_p) begin
          w_state_nxt = c_st_done;
        end else if (r_tmo == c_tmo_last) begin
          // An abandoned wait still has to swallow the rest of a dropped frame.
          w_state_nxt = w_inflight_nxt ? c_st_drop : c_st_idle;
        end
      end
      c_st_drop: begin
        if (fft_valid && fft_last) begin
          w_state_nxt = c_st_idle;
        end
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    w_start    = w_in_gate && fft_valid && (fft_user == '0);
    w_fwd_en   = w_start || ((r_state == c_st_stream) && fft_valid);
    w_beat_idx = (r_bin_cnt == c_cnt_sat) ? r_bin_cnt : r_bin_cnt + 1'b1;
    w_len_err  = (w_start && fft_last && !c_single) ||
                 ((r_state == c_st_stream) && fft_valid && fft_last && (w_beat_idx != c_cnt_last));
    w_drop_inc = fft_valid && fft_last &&
                 ((r_state == c_st_wait) || (r_state == c_st_drop) ||
                  ((r_state == c_st_done) && r_inflight) ||
                  (w_in_gate && (fft_user != '0)));
    w_res_fire = (r_state == c_st_wait) && w_got_k && w_got_p;
    w_timeout  = (r_state == c_st_wait) && !w_res_fire && (r_tmo == c_tmo_last);
    w_k_hold_nxt     = ((r_state == c_st_wait) && k_max_valid) ? k_max : r_k_max_hold;
    w_phase_hold_nxt = (phase_in_valid && (phase_bin == r_target_bin)) ? phase_in : r_phase_hold;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fwd_data     <= '0;
      fwd_user     <= '0;
      fwd_valid    <= 1'b0;
      fwd_last     <= 1'b0;
      r_bin_cnt    <= '0;
      r_tmo        <= '0;
      r_got_k      <= 1'b0;
      r_got_p      <= 1'b0;
      r_inflight   <= 1'b0;
      r_k_max_hold <= '0;
      r_phase_hold <= '0;
      r_target_bin <= '0;
      res_k_max    <= '0;
      res_phase    <= '0;
      res_valid    <= 1'b0;
      busy         <= 1'b0;
      drop_count   <= '0;
      err_len      <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      fwd_valid <= w_fwd_en;
      fwd_last  <= w_fwd_en & fft_last;
      if (w_fwd_en) begin
        fwd_data <= fft_data;
        fwd_user <= fft_user;
      end

      if (w_start) begin
        r_bin_cnt <= '0;
      end else if ((r_state == c_st_stream) && fft_valid) begin
        r_bin_cnt <= w_beat_idx;
      end

      if (r_state == c_st_wait) begin
        r_got_k <= w_got_k;
        r_got_p <= w_got_p;
        r_tmo   <= r_tmo + 1'b1;
      end else begin
        r_got_k <= 1'b0;
        r_got_p <= 1'b0;
        r_tmo   <= '0;
      end
      r_inflight <= (r_state == c_st_wait) ? w_inflight_nxt : 1'b0;

      r_k_max_hold <= w_k_hold_nxt;
      r_phase_hold <= w_phase_hold_nxt;

      // Results land in the DONE cycle; next frame's phase is taken at this peak.
      res_valid <= w_res_fire;
      if (w_res_fire) begin
        res_k_max    <= w_k_hold_nxt;
        res_phase    <= w_phase_hold_nxt;
        r_target_bin <= w_k_hold_nxt;
      end

      busy <= (w_state_nxt == c_st_stream) || (w_state_nxt == c_st_wait);

      if (w_len_err) begin
        err_len <= 1'b1;
      end
      if (w_timeout) begin
        err_timeout <= 1'b1;
      end
      if (w_drop_inc && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire
